// File: rtl/toggle_sync_capture_pkg.sv
// toggle_sync_capture_pkg: shared UART crossing constants
package toggle_sync_capture_pkg;
  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int OVR_CNT_W_DEF   = 8;
endpackage

// File: rtl/toggle_sync_capture_sync_bit.sv
// sync_bit: N-stage single-bit synchroniser, reset to 0
module sync_bit
  import toggle_sync_capture_pkg::*;
#(
  parameter int N = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [N-1:0] ff;
  always_ff @(posedge clk)
    if (rst) ff <= '0;
    else     ff <= {ff[N-2:0], d};
  assign q = ff[N-1];
endmodule

// File: rtl/toggle_sync_capture.sv
// toggle_sync_capture: toggle-CDC receiver with byte capture, valid/ready output and overrun count
module toggle_sync_capture
  import toggle_sync_capture_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int OVR_CNT_W   = OVR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 toggle_in,
  input  logic [DATA_W-1:0]    data_in,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  input  logic                 out_ready,
  output logic                 pulse,
  output logic                 ack_toggle,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] overrun_cnt,
  input  logic                 clr_overrun
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic sync_q, tog_prev, tog_edge, accept, load, drop;
  sync_bit #(.N(SYNC_STAGES)) u_sync (.clk, .rst, .d(toggle_in), .q(sync_q));
  assign tog_edge  = sync_q != tog_prev;
  assign out_valid = state == FULL;
  assign accept    = out_valid && out_ready;
  always_comb begin
    load     = tog_edge && (!out_valid || accept);
    drop     = tog_edge && out_valid && !accept;
    state_nx = (tog_edge || (out_valid && !out_ready)) ? FULL : EMPTY;
  end
  always_ff @(posedge clk)
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  // a drop coinciding with a clear leaves exactly that one drop recorded
  always_ff @(posedge clk)
    if (rst) begin
      tog_prev    <= 1'b0;
      out_data    <= '0;
      pulse       <= 1'b0;
      ack_toggle  <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      tog_prev    <= sync_q;
      pulse       <= tog_edge;
      out_data    <= load ? data_in : out_data;
      ack_toggle  <= ack_toggle ^ accept;
      overrun     <= drop || (overrun && !clr_overrun);
      overrun_cnt <= drop ? (clr_overrun ? OVR_CNT_W'(1) :
                             (&overrun_cnt) ? overrun_cnt : overrun_cnt + OVR_CNT_W'(1)) :
                     clr_overrun ? '0 : overrun_cnt;
    end
endmodule

// File: tb/tb_toggle_sync_capture.sv
// tb_toggle_sync_capture: scoreboard bench with slot-based reference model
module tb_toggle_sync_capture;
  localparam int S = 2;
  typedef struct {int due; logic [7:0] b;} arr_t;
  logic clk = 1'b0;
  logic rst, toggle_in, out_ready, clr_overrun;
  logic [7:0] data_in, out_data, overrun_cnt;
  logic out_valid, pulse, ack_toggle, overrun;
  int tests = 0, fails = 0, cyc = 0, n_acc = 0;
  arr_t pend[$];
  logic [7:0] exp_q[$];
  logic m_valid = 0, m_pulse = 0, m_ack = 0, m_ovr = 0, arr, acc, drp;
  logic [7:0] m_data = 0, got;
  int m_cnt = 0;

  toggle_sync_capture #(.DATA_W(8), .SYNC_STAGES(S), .OVR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .toggle_in(toggle_in), .data_in(data_in),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .pulse(pulse), .ack_toggle(ack_toggle), .overrun(overrun),
    .overrun_cnt(overrun_cnt), .clr_overrun(clr_overrun));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flip(input logic [7:0] b);
    data_in = b;
    toggle_in = ~toggle_in;
    pend.push_back('{due: cyc + 1 + S, b: b});
  endtask

  // reference: one holding slot; each byte lands S+1 edges after its flip
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("pulse", pulse, m_pulse);
      chk("out_valid", out_valid, m_valid);
      chk("ack_toggle", ack_toggle, m_ack);
      chk("overrun", overrun, m_ovr);
      chk("overrun_cnt", overrun_cnt, m_cnt);
      if (m_valid) chk("out_data", out_data, m_data);
    end
    if (rst) begin
      {m_valid, m_pulse, m_ack, m_ovr} = '0;
      m_data = 0;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      arr = pend.size() > 0 && pend[0].due == cyc + 1;
      acc = m_valid && out_ready;
      drp = arr && m_valid && !acc;
      m_pulse = arr;
      if (acc) m_ack = !m_ack;
      if (arr && !drp) begin
        m_data = pend[0].b;
        exp_q.push_back(m_data);
      end
      m_valid = arr || (m_valid && !acc);
      if (drp) begin
        m_ovr = 1;
        m_cnt = clr_overrun ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
      end else if (clr_overrun) begin
        m_ovr = 0;
        m_cnt = 0;
      end
      if (arr) void'(pend.pop_front());
    end
  end

  always @(negedge clk)
    if (cyc > 0 && !rst && out_valid && out_ready) begin
      n_acc++;
      if (exp_q.size() == 0) chk("unexpected_accept", out_data, 32'hffff_ffff);
      else begin
        got = exp_q.pop_front();
        chk("accepted_byte", out_data, got);
      end
    end

  initial begin
    rst = 1; toggle_in = 0; data_in = 0; out_ready = 0; clr_overrun = 0;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ack", ack_toggle, 0);
    chk("rst_cnt", overrun_cnt, 0);
    // single byte
    out_ready = 1;
    flip(8'hA5);
    repeat (S + 1) tick();
    chk("single_pulse", pulse, 1);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    tick();
    chk("single_ack", ack_toggle, 1);
    chk("single_done", out_valid, 0);
    chk("single_ovr", overrun, 0);
    // backpressure overrun
    out_ready = 0;
    flip(8'h11); repeat (S + 1) tick();
    flip(8'h22); repeat (S + 1) tick();
    chk("ovr_data", out_data, 8'h11);
    chk("ovr_flag", overrun, 1);
    chk("ovr_cnt", overrun_cnt, 1);
    out_ready = 1; tick(); out_ready = 0;
    chk("ovr_ack", ack_toggle, 0);
    chk("ovr_drained", out_valid, 0);
    clr_overrun = 1; tick(); clr_overrun = 0;
    chk("clr_flag", overrun, 0);
    chk("clr_cnt", overrun_cnt, 0);
    // accept and new edge on the same cycle
    flip(8'h33); repeat (S + 1) tick();
    flip(8'h44); repeat (S) tick();
    out_ready = 1; tick(); out_ready = 0;
    chk("ae_data", out_data, 8'h44);
    chk("ae_valid", out_valid, 1);
    chk("ae_ovr", overrun, 0);
    chk("ae_ack", ack_toggle, 1);
    // saturation
    for (int i = 0; i < 260; i++) begin
      flip(8'($urandom_range(0, 255)));
      repeat (S + 1) tick();
    end
    chk("sat_cnt", overrun_cnt, 255);
    chk("sat_data", out_data, 8'h44);
    flip(8'h66); repeat (S) tick();
    clr_overrun = 1; tick(); clr_overrun = 0;
    chk("clr_drop_cnt", overrun_cnt, 1);
    chk("clr_drop_flag", overrun, 1);
    // reset mid-operation
    out_ready = 1;
    flip(8'h77); repeat (S + 2) tick();
    out_ready = 0;
    flip(8'h5A); repeat (S + 1) tick();
    chk("mid_data", out_data, 8'h5A);
    chk("mid_ack_pre", ack_toggle, 1);
    rst = 1; toggle_in = 0; pend.delete();
    tick();
    rst = 0;
    chk("mid_valid", out_valid, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_ack", ack_toggle, 0);
    chk("mid_cnt", overrun_cnt, 0);
    repeat (4) tick();
    chk("mid_no_pulse", pulse, 0);
    // random stream
    n_acc = 0;
    for (int i = 0; i < 256; i++) begin
      flip(8'(i));
      for (int j = 0; j < 3; j++) begin
        out_ready = $urandom_range(0, 3) != 0;
        tick();
      end
    end
    out_ready = 1;
    repeat (6) tick();
    chk("stream_count", n_acc, 256 - int'(overrun_cnt));
    chk("stream_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/toggle_sync_capture.md
# toggle_sync_capture

Destination-domain receiver for the UART RX crossing: takes the level toggle that flips once per received byte in the UART clock domain, resynchronises it into `clk`, regenerates a single-cycle pulse, captures the accompanying byte and presents it on a valid/ready interface to the RX FIFO write port. It returns an acknowledge toggle to the source domain and counts bytes lost to backpressure (overrun).

## Interface
- `DATA_W`, 8: width of captured data bus.
- `SYNC_STAGES`, 2: flip-flop stages in the toggle synchroniser; legal range 2..4.
- `OVR_CNT_W`, 8: width of the saturating overrun counter.

- `clk`  in  1: destination clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `toggle_in`  in  1: asynchronous toggle from source domain; every level change = one new byte.
- `data_in`  in  DATA_W: source byte; quasi-static, stable from before `toggle_in` flips until `ack_toggle` is seen to flip.
- `out_valid`  out  1: `out_data` holds an unaccepted byte.
- `out_data`  out  DATA_W: captured byte.
- `out_ready`  in  1: downstream (FIFO write side) accepts when high with `out_valid`.
- `pulse`  out  1: one-cycle strobe per detected toggle edge (including overruns).
- `ack_toggle`  out  1: flips once per accepted byte; returned to source domain.
- `overrun`  out  1: sticky; set when a byte is dropped.
- `overrun_cnt`  out  OVR_CNT_W: dropped-byte count, saturates at all-ones.
- `clr_overrun`  in  1: synchronous clear of `overrun` and `overrun_cnt`.

## Operation
- Synchroniser chain `sync[0..SYNC_STAGES-1]`, plus `tog_prev` register sampling `sync[last]` every cycle. Edge = `sync[last] != tog_prev`.
- States: EMPTY (`out_valid`=0), FULL (`out_valid`=1).
- EMPTY + edge: load `data_in` into `out_data`, go FULL.
- FULL + accept (`out_valid && out_ready`) + no edge: go EMPTY, flip `ack_toggle`.
- FULL + accept + edge: flip `ack_toggle`, load new byte, stay FULL; no overrun.
- FULL + no accept + edge: keep old byte, set `overrun`, increment `overrun_cnt` (saturate); no `ack_toggle` flip.
- `pulse` registered: high exactly one cycle per edge, in the cycle `out_valid` rises/reloads (or overrun is flagged).
- `clr_overrun` with simultaneous new overrun: overrun wins; `overrun`=1, `overrun_cnt`=1.
- `out_data` does not change while FULL except on accept+edge.
- Reset values: sync chain, `tog_prev`, `out_valid`, `out_data`, `pulse`, `ack_toggle`, `overrun`, `overrun_cnt` all 0; state EMPTY. Source toggle also resets to 0 (same `rst` tree), so no spurious edge on release.
- Reset mid-operation: pending byte discarded, no `ack_toggle` flip generated.

## Timing
- Edge 0 = first rising edge where `sync[0]` samples the new `toggle_in` level. `sync[last]` updates at edge SYNC_STAGES-1; `pulse`/`out_valid`/`out_data` update at edge SYNC_STAGES. With defaults: valid 2 edges after first sampling edge.
- Accept at edge n: `out_valid` low and `ack_toggle` flipped after edge n.
- Minimum toggle spacing for lossless operation with `out_ready`=1: SYNC_STAGES+1 cycles; consecutive edges closer than one cycle are not resolvable (source protocol forbids them).
- Throughput: one byte per cycle at the valid/ready port.

## Structure
- Sub-module `sync_bit`: parameterised N-stage single-bit synchroniser, reset-to-0, reused on the source side for `ack_toggle`.
- `DATA_W` default and `SYNC_STAGES` default live in the shared UART constants package; state encoding (EMPTY/FULL) is local.

## Test plan
- Single byte: reset, `data_in`=0xA5, flip `toggle_in`, `out_ready`=1 -> `pulse` once, `out_data`=0xA5 valid one cycle, `ack_toggle` 0->1, `overrun`=0.
- Backpressure overrun: `out_ready`=0, send 0x11 then 0x22 -> `out_data` stays 0x11, `overrun`=1, `overrun_cnt`=1; then `out_ready`=1 -> 0x11 accepted, `ack_toggle` flips once.
- Accept+edge same cycle: FULL with 0x33, new toggle lands on accept cycle with 0x44 -> `out_data`=0x44 valid next cycle, `overrun`=0, `ack_toggle` flipped once.
- Saturation/clear: `OVR_CNT_W`=2, 5 dropped bytes -> `overrun_cnt`=3; `clr_overrun` with simultaneous drop -> `overrun_cnt`=1, `overrun`=1.
- Reset mid-operation: FULL with 0x5A, assert `rst` one cycle -> all outputs 0, no `pulse`, `ack_toggle`=0 after release.
- Back-to-back stream: 256 bytes 0x00..0xFF, toggle every 3 cycles, random `out_ready` with ≥50% duty -> received sequence in order, count = 256 − `overrun_cnt`.
